ps2_keyboard_axi_slave: RTL and testbench
=========================================

# ps2_keyboard_axi_slave

AXI4-Lite responder exposing the PS/2 keyboard IP to the processor through the S00_AXI port. It terminates write and read transactions from the bus master, holds a control/scratch register pair, and buffers incoming scancodes in an 8-deep FIFO that software drains through a pop-on-read data register. It sits between the scancode decoder and the block-design AXI interconnect.

## Interface

Parameters:
- C_S_AXI_DATA_WIDTH, 32, bus data width (only 32 supported)
- C_S_AXI_ADDR_WIDTH, 4, byte address width; four 32-bit registers
- FIFO_DEPTH, 8, scancode FIFO entries (power of two)

Ports:
- clock  in  1  sole clock; all logic rising-edge
- reset  in  1  synchronous, active-high reset
- s_axi_awaddr  in  4  write address
- s_axi_awprot  in  3  ignored
- s_axi_awvalid / s_axi_awready  in / out  1  write-address handshake
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  byte strobes
- s_axi_wvalid / s_axi_wready  in / out  1  write-data handshake
- s_axi_bresp  out  2  always 2'b00 (OKAY)
- s_axi_bvalid / s_axi_bready  out / in  1  write response
- s_axi_araddr  in  4  read address
- s_axi_arprot  in  3  ignored
- s_axi_arvalid / s_axi_arready  in / out  1  read-address handshake
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  always 2'b00
- s_axi_rvalid / s_axi_rready  out / in  1  read response
- scancode_data  in  8  decoded scancode
- scancode_valid  in  1  one-cycle push strobe
- irq  out  1  level interrupt

## Operation

- Register decode uses addr[3:2]; addr[1:0] ignored. Every access returns OKAY.
- 0x0 CTRL (rw): bit0 ENABLE (gates FIFO pushes), bit1 IRQ_EN, bit2 CLEAR (write-1 pulse, reads 0). Writes honour wstrb.
- 0x4 STATUS (ro, bit8 W1C): [3:0] count, bit8 OVERFLOW (sticky), bit9 EMPTY, bit10 FULL.
- 0x8 DATA (ro): [7:0] head scancode, bit31 VALID (=!empty). AR handshake on DATA pops if non-empty; empty read returns 0 with no side effect. Writes ignored.
- 0xC SCRATCH (rw): plain byte-strobed storage.
- Write path: AW and W accepted independently in either order; each held in a latch. awready low while AW latched or bvalid high; wready likewise. When both latched and bvalid low, register write occurs and bvalid rises next cycle; held until bready.
- Read path: arready = !rvalid. On AR handshake rdata/rvalid register next cycle; rdata stable until rready.
- FIFO push when scancode_valid && ENABLE. Full and no pop: drop, set OVERFLOW. Full with simultaneous pop: both proceed, no overflow. CLEAR in same cycle as push/pop: CLEAR wins (count 0, push discarded). OVERFLOW W1C in same cycle as new overflow: stays set.
- irq = IRQ_EN && (!empty || OVERFLOW).

## Timing

- Reset values: all ready/valid outputs 0, rdata 0, bresp/rresp 0, irq 0, CTRL 0, SCRATCH 0, FIFO empty, OVERFLOW 0. arready/awready/wready rise the first cycle after reset deasserts.
- Write: AW+W same cycle → bvalid next cycle (latency 1); back-to-back throughput one write per 2 cycles with bready held high.
- Read: AR → rvalid next cycle (latency 1); pop visible in STATUS count from that next cycle.
- Reset mid-transaction abandons it; no response is issued for it.

## Configuration

- PS2_KBD_IRQ_EN defined: IRQ_EN bit and irq logic present as above.
- Undefined: irq tied 0, CTRL bit1 reads 0 and ignores writes.

## Structure

- Package ps2_keyboard_pkg: register offsets, CTRL/STATUS bit indices, AXI_RESP_OKAY constant.
- Sub-module ps2_scancode_fifo: synchronous FIFO with push, pop, clear, count, full, empty.

## Test plan

- Write 0x3 to CTRL, 0xDEADBEEF to SCRATCH, wstrb 4'b0011 write 0xFFFFFFFF to SCRATCH → reads 0x00000003, 0xDEADFFFF; all resp OKAY.
- W presented 3 cycles before AW → single write, bvalid once, 1 cycle after AW handshake.
- ENABLE=1, push 0x1C,0x32 → STATUS count 2; DATA reads 0x8000001C then 0x80000032, then 0x00000000; EMPTY=1.
- Push 9 codes into 8-deep FIFO → FULL=1, OVERFLOW=1, irq=1 (IRQ_EN); write 0x100 to STATUS clears OVERFLOW.
- Push while full with same-cycle DATA pop → count stays 8, OVERFLOW stays 0.
- Hold rready low 5 cycles → rdata/rvalid stable, arready low throughout.

Source files
------------

// File: rtl/ps2_keyboard_pkg.sv
// Shared register map, bit positions and helpers for the PS/2 keyboard AXI4-Lite slave.
package ps2_keyboard_pkg;

    typedef enum logic [1:0] {
        REG_CTRL    = 2'd0,
        REG_STATUS  = 2'd1,
        REG_DATA    = 2'd2,
        REG_SCRATCH = 2'd3
    } reg_sel_e;

    localparam logic [3:0] ADDR_CTRL    = 4'h0;
    localparam logic [3:0] ADDR_STATUS  = 4'h4;
    localparam logic [3:0] ADDR_DATA    = 4'h8;
    localparam logic [3:0] ADDR_SCRATCH = 4'hC;

    localparam int CTRL_ENABLE   = 0;
    localparam int CTRL_IRQ_EN   = 1;
    localparam int CTRL_CLEAR    = 2;
    localparam int STAT_OVERFLOW = 8;
    localparam int STAT_EMPTY    = 9;
    localparam int STAT_FULL     = 10;
    localparam int DATA_VALID    = 31;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++)
            merged[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        return merged;
    endfunction

endpackage

// File: rtl/ps2_scancode_fifo.sv
// Synchronous scancode FIFO; a push into a full FIFO only lands when a pop frees a slot
// in the same cycle, and clear overrides both.
module ps2_scancode_fifo
    import ps2_keyboard_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_clear,
    input  logic [WIDTH-1:0]           i_din,
    output logic [WIDTH-1:0]           o_dout,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_do_push && !i_clear)
            r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/ps2_keyboard_axi_slave.sv
// AXI4-Lite register front end for the PS/2 keyboard: CTRL/STATUS/DATA/SCRATCH plus scancode FIFO.
// Define PS2_KBD_IRQ_EN to build the IRQ_EN control bit and the level interrupt.
module ps2_keyboard_axi_slave
    import ps2_keyboard_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int FIFO_DEPTH         = 8
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                      s_axi_awprot,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                      s_axi_arprot,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    input  logic [7:0]                      scancode_data,
    input  logic                            scancode_valid,
    output logic                            irq
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic              r_live;
    logic              r_aw_held;
    logic              r_w_held;
    logic [1:0]        r_aw_sel;
    logic [DW-1:0]     r_wdata;
    logic [DW/8-1:0]   r_wstrb;
    logic              r_bvalid;
    logic              r_rvalid;
    logic [DW-1:0]     r_rdata;
    logic              r_enable;
    logic              r_overflow;
    logic [DW-1:0]     r_scratch;

    logic              w_aw_hs, w_w_hs, w_ar_hs, w_wr_fire;
    reg_sel_e          w_wr_sel, w_rd_sel;
    logic [DW-1:0]     w_wr_data;
    logic [DW/8-1:0]   w_wr_strb;
    logic              w_clear, w_pop, w_push_req, w_ovf_set, w_ovf_clr;
    logic              w_irq_en;
    logic [7:0]        w_head;
    logic [CW-1:0]     w_count;
    logic              w_full, w_empty;
    logic [DW-1:0]     w_status, w_rd_data;
    logic              w_unused;

    assign w_unused = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // r_live keeps every ready low until the first cycle after reset is released.
    assign s_axi_awready = r_live && !r_aw_held && !r_bvalid;
    assign s_axi_wready  = r_live && !r_w_held && !r_bvalid;
    assign s_axi_arready = r_live && !r_rvalid;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_bresp   = AXI_RESP_OKAY;
    assign s_axi_rresp   = AXI_RESP_OKAY;

    assign w_aw_hs   = s_axi_awvalid && s_axi_awready;
    assign w_w_hs    = s_axi_wvalid && s_axi_wready;
    assign w_ar_hs   = s_axi_arvalid && s_axi_arready;
    assign w_wr_fire = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs) && !r_bvalid;
    assign w_wr_sel  = reg_sel_e'(r_aw_held ? r_aw_sel : s_axi_awaddr[3:2]);
    assign w_wr_data = r_w_held ? r_wdata : s_axi_wdata;
    assign w_wr_strb = r_w_held ? r_wstrb : s_axi_wstrb;
    assign w_rd_sel  = reg_sel_e'(s_axi_araddr[3:2]);

    assign w_clear    = w_wr_fire && (w_wr_sel == REG_CTRL) && w_wr_strb[0] && w_wr_data[CTRL_CLEAR];
    assign w_pop      = w_ar_hs && (w_rd_sel == REG_DATA) && !w_empty;
    assign w_push_req = scancode_valid && r_enable;
    assign w_ovf_set  = w_push_req && w_full && !w_pop && !w_clear;
    assign w_ovf_clr  = w_wr_fire && (w_wr_sel == REG_STATUS) && w_wr_strb[1] && w_wr_data[STAT_OVERFLOW];

    ps2_scancode_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push_req),
        .i_pop   (w_pop),
        .i_clear (w_clear),
        .i_din   (scancode_data),
        .o_dout  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef PS2_KBD_IRQ_EN
    logic r_irq_en;
    always_ff @(posedge clock) begin
        if (reset)
            r_irq_en <= 1'b0;
        else if (w_wr_fire && (w_wr_sel == REG_CTRL) && w_wr_strb[0])
            r_irq_en <= w_wr_data[CTRL_IRQ_EN];
    end
    assign w_irq_en = r_irq_en;
`else
    assign w_irq_en = 1'b0;
`endif

    assign irq = w_irq_en && (!w_empty || r_overflow);

    always_comb begin
        w_status                = '0;
        w_status[CW-1:0]        = w_count;
        w_status[STAT_OVERFLOW] = r_overflow;
        w_status[STAT_EMPTY]    = w_empty;
        w_status[STAT_FULL]     = w_full;
        w_rd_data               = '0;
        unique case (w_rd_sel)
            REG_CTRL: begin
                w_rd_data[CTRL_ENABLE] = r_enable;
                w_rd_data[CTRL_IRQ_EN] = w_irq_en;
            end
            REG_STATUS:  w_rd_data = w_status;
            REG_DATA: if (!w_empty) begin
                w_rd_data[7:0]        = w_head;
                w_rd_data[DATA_VALID] = 1'b1;
            end
            REG_SCRATCH: w_rd_data = r_scratch;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_live     <= 1'b0;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_aw_sel   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bvalid   <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_enable   <= 1'b0;
            r_overflow <= 1'b0;
            r_scratch  <= '0;
        end else begin
            r_live <= 1'b1;
            // A fire consumes both halves, whether latched earlier or arriving this cycle.
            if (w_wr_fire) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_aw_sel  <= s_axi_awaddr[3:2];
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_wdata  <= s_axi_wdata;
                    r_wstrb  <= s_axi_wstrb;
                end
                if (r_bvalid && s_axi_bready)
                    r_bvalid <= 1'b0;
            end

            if (w_wr_fire && (w_wr_sel == REG_CTRL) && w_wr_strb[0])
                r_enable <= w_wr_data[CTRL_ENABLE];
            if (w_wr_fire && (w_wr_sel == REG_SCRATCH))
                r_scratch <= apply_wstrb(r_scratch, w_wr_data, w_wr_strb);

            // A new overflow beats a same-cycle write-1-to-clear.
            if (w_ovf_set)
                r_overflow <= 1'b1;
            else if (w_ovf_clr)
                r_overflow <= 1'b0;

            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
            end else if (r_rvalid && s_axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_axi_slave.sv
// Self-checking bench: register table, scripted FIFO corner cases, then random traffic vs a queue model.
module tb_ps2_keyboard_axi_slave;
    import ps2_keyboard_pkg::*;

`ifdef PS2_KBD_IRQ_EN
    localparam bit IRQ_SUP = 1'b1;
`else
    localparam bit IRQ_SUP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  s_axi_awaddr;
    logic [2:0]  s_axi_awprot;
    logic        s_axi_awvalid, s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid, s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid, s_axi_bready;
    logic [3:0]  s_axi_araddr;
    logic [2:0]  s_axi_arprot;
    logic        s_axi_arvalid, s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid, s_axi_rready;
    logic [7:0]  scancode_data;
    logic        scancode_valid;
    logic        irq;

    always #5 clock = ~clock;

    ps2_keyboard_axi_slave dut (
        .clock(clock), .reset(reset),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .scancode_data(scancode_data), .scancode_valid(scancode_valid),
        .irq(irq)
    );

    int n_pass = 0;
    int n_total = 0;

    // Reference model: the FIFO is just a byte queue, registers are plain variables.
    logic [7:0]  q[$];
    logic        m_en = 1'b0;
    logic        m_irq_en = 1'b0;
    logic        m_ovf = 1'b0;
    logic [31:0] m_scr = '0;

    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[14];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] v;
        v = '0;
        v[3:0] = 4'(q.size());
        v[8]   = m_ovf;
        v[9]   = (q.size() == 0);
        v[10]  = (q.size() == 8);
        return v;
    endfunction

    function automatic logic [31:0] model_read(input logic [3:0] a);
        case (a[3:2])
            2'd0:    return {30'b0, m_irq_en, m_en};
            2'd1:    return exp_status();
            2'd2:    return (q.size() != 0) ? {24'h800000, q[0]} : 32'h0;
            default: return m_scr;
        endcase
    endfunction

    function automatic logic exp_irq();
        return IRQ_SUP && m_irq_en && ((q.size() != 0) || m_ovf);
    endfunction

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                             input bit push, input logic [7:0] code);
        bit aw_ok, w_ok;
        int n;
        s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
        scancode_data = code; scancode_valid = push;
        n = 0;
        while ((s_axi_awvalid || s_axi_wvalid) && n < 20) begin
            @(negedge clock);
            aw_ok = s_axi_awvalid && s_axi_awready;
            w_ok  = s_axi_wvalid && s_axi_wready;
            @(posedge clock); #1;
            scancode_valid = 1'b0;
            if (aw_ok) s_axi_awvalid = 1'b0;
            if (w_ok)  s_axi_wvalid = 1'b0;
            n++;
        end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        check("wr_accept_cycles", 32'(n), 32'd1);
        check("bvalid_lat1", 32'(s_axi_bvalid), 32'd1);
        check("bresp", 32'(s_axi_bresp), 32'(AXI_RESP_OKAY));
        s_axi_bready = 1'b1;
        @(posedge clock); #1;
        s_axi_bready = 1'b0;
        check("bvalid_drop", 32'(s_axi_bvalid), 32'd0);
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
        bit ok;
        int n;
        s_axi_araddr = a; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
        ok = 1'b0; n = 0;
        while (!ok && n < 20) begin
            @(negedge clock);
            ok = s_axi_arready;
            @(posedge clock); #1;
            n++;
        end
        s_axi_arvalid = 1'b0;
        check("ar_accept_cycles", 32'(n), 32'd1);
        check("rvalid_lat1", 32'(s_axi_rvalid), 32'd1);
        check("rresp", 32'(s_axi_rresp), 32'(AXI_RESP_OKAY));
        d = s_axi_rdata;
        @(posedge clock); #1;
        s_axi_rready = 1'b0;
    endtask

    task automatic mwrite(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        axi_write(a, d, s, 1'b0, 8'h00);
        case (a[3:2])
            2'd0: if (s[0]) begin
                m_en = d[0];
                m_irq_en = IRQ_SUP && d[1];
                if (d[2]) q.delete();
            end
            2'd1: if (s[1] && d[8]) m_ovf = 1'b0;
            2'd3: for (int b = 0; b < 4; b++) if (s[b]) m_scr[8*b +: 8] = d[8*b +: 8];
            default: ;
        endcase
    endtask

    task automatic rd(input logic [3:0] a, input string nm, input logic [31:0] exp);
        logic [31:0] d;
        axi_read(a, d);
        check(nm, d, exp);
        if (a[3:2] == 2'd2 && q.size() != 0) q.delete(0);
    endtask

    task automatic push_code(input logic [7:0] c);
        scancode_data = c; scancode_valid = 1'b1;
        @(posedge clock); #1;
        scancode_valid = 1'b0;
        if (m_en) begin
            if (q.size() < 8) q.push_back(c);
            else m_ovf = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] ctrl3, exp, d;
        int op;
        logic [3:0] s;
        ctrl3 = IRQ_SUP ? 32'h3 : 32'h1;
        reset = 1'b1;
        s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 0; s_axi_bready = 0;
        s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 0; s_axi_rready = 0;
        scancode_data = '0; scancode_valid = 0;

        repeat (3) @(posedge clock);
        #1;
        check("rst_awready", 32'(s_axi_awready), 0);
        check("rst_wready", 32'(s_axi_wready), 0);
        check("rst_arready", 32'(s_axi_arready), 0);
        check("rst_bvalid", 32'(s_axi_bvalid), 0);
        check("rst_rvalid", 32'(s_axi_rvalid), 0);
        check("rst_rdata", s_axi_rdata, 0);
        check("rst_resp", 32'({s_axi_bresp, s_axi_rresp}), 0);
        check("rst_irq", 32'(irq), 0);
        reset = 1'b0;
        @(negedge clock);
        check("awready_pre_live", 32'(s_axi_awready), 0);
        @(posedge clock); #1;
        check("ready_after_rst", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'h7);

        tbl[0]  = '{1'b1, 4'h0, 32'h00000003, 4'hF, 32'h0};
        tbl[1]  = '{1'b1, 4'hC, 32'hDEADBEEF, 4'hF, 32'h0};
        tbl[2]  = '{1'b1, 4'hC, 32'hFFFFFFFF, 4'h3, 32'h0};
        tbl[3]  = '{1'b0, 4'h0, 32'h0, 4'h0, ctrl3};
        tbl[4]  = '{1'b0, 4'hC, 32'h0, 4'h0, 32'hDEADFFFF};
        tbl[5]  = '{1'b1, 4'hC, 32'h12345678, 4'h8, 32'h0};
        tbl[6]  = '{1'b0, 4'hF, 32'h0, 4'h0, 32'h12ADFFFF};
        tbl[7]  = '{1'b1, 4'h8, 32'hFFFFFFFF, 4'hF, 32'h0};
        tbl[8]  = '{1'b0, 4'h8, 32'h0, 4'h0, 32'h00000000};
        tbl[9]  = '{1'b0, 4'h4, 32'h0, 4'h0, 32'h00000200};
        tbl[10] = '{1'b1, 4'h0, 32'h00000000, 4'h0, 32'h0};
        tbl[11] = '{1'b0, 4'h2, 32'h0, 4'h0, ctrl3};
        tbl[12] = '{1'b1, 4'h4, 32'hFFFFFFFF, 4'hF, 32'h0};
        tbl[13] = '{1'b0, 4'h4, 32'h0, 4'h0, 32'h00000200};
        for (int i = 0; i < 14; i++) begin
            if (tbl[i].wr) mwrite(tbl[i].addr, tbl[i].data, tbl[i].strb);
            else rd(tbl[i].addr, $sformatf("tbl%0d", i), tbl[i].exp);
        end

        push_code(8'h1C);
        push_code(8'h32);
        rd(4'h4, "two_status", 32'h00000002);
        rd(4'h8, "pop0", 32'h8000001C);
        rd(4'h8, "pop1", 32'h80000032);
        rd(4'h8, "pop_empty", 32'h00000000);
        rd(4'h4, "drained_status", 32'h00000200);
        check("irq_empty", 32'(irq), 0);

        for (int i = 0; i < 9; i++) push_code(8'(8'h10 + i));
        rd(4'h4, "ovf_status", 32'h00000508);
        check("ovf_irq", 32'(irq), 32'(IRQ_SUP));
        // W1C racing a fresh overflow: the set must win.
        axi_write(4'h4, 32'h100, 4'hF, 1'b1, 8'h55);
        rd(4'h4, "w1c_race_status", 32'h00000508);
        mwrite(4'h4, 32'h100, 4'hF);
        rd(4'h4, "w1c_status", 32'h00000408);
        check("irq_nonempty", 32'(irq), 32'(IRQ_SUP));

        // Push into a full FIFO in the same cycle as a DATA pop.
        s_axi_araddr = 4'h8; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
        scancode_data = 8'hAA; scancode_valid = 1'b1;
        @(negedge clock);
        check("pp_arready", 32'(s_axi_arready), 1);
        @(posedge clock); #1;
        s_axi_arvalid = 1'b0; scancode_valid = 1'b0;
        q.delete(0); q.push_back(8'hAA);
        check("pp_rvalid", 32'(s_axi_rvalid), 1);
        check("pp_rdata", s_axi_rdata, 32'h80000010);
        s_axi_rready = 1'b1;
        @(posedge clock); #1;
        s_axi_rready = 1'b0;
        rd(4'h4, "pp_status", 32'h00000408);

        // Back-pressured read response must hold still.
        exp = exp_status();
        s_axi_araddr = 4'h4; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
        @(posedge clock); #1;
        s_axi_arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("hold_rvalid", 32'(s_axi_rvalid), 1);
            check("hold_rdata", s_axi_rdata, exp);
            check("hold_arready", 32'(s_axi_arready), 0);
            @(posedge clock); #1;
        end
        s_axi_rready = 1'b1;
        @(posedge clock); #1;
        s_axi_rready = 1'b0;
        check("hold_release", 32'(s_axi_rvalid), 0);

        // CLEAR in the same cycle as a push into a full FIFO.
        axi_write(4'h0, 32'h7, 4'hF, 1'b1, 8'h77);
        m_en = 1'b1; m_irq_en = IRQ_SUP; q.delete();
        rd(4'h4, "clr_status", 32'h00000200);
        rd(4'h0, "clr_ctrl", ctrl3);

        // W arrives three cycles ahead of AW.
        s_axi_wdata = 32'hCAFEF00D; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
        @(posedge clock); #1;
        s_axi_wvalid = 1'b0;
        check("wfirst_wready_low", 32'(s_axi_wready), 0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clock); #1;
            check("wfirst_no_bvalid", 32'(s_axi_bvalid), 0);
        end
        s_axi_awaddr = 4'hC; s_axi_awvalid = 1'b1;
        @(negedge clock);
        check("wfirst_awready", 32'(s_axi_awready), 1);
        @(posedge clock); #1;
        s_axi_awvalid = 1'b0;
        check("wfirst_bvalid", 32'(s_axi_bvalid), 1);
        s_axi_bready = 1'b1;
        @(posedge clock); #1;
        s_axi_bready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("wfirst_single_b", 32'(s_axi_bvalid), 0);
            @(posedge clock); #1;
        end
        m_scr = 32'hCAFEF00D;
        rd(4'hC, "wfirst_scratch", 32'hCAFEF00D);

        for (int it = 0; it < 300; it++) begin
            op = $urandom_range(0, 7);
            d = $urandom;
            s = 4'($urandom);
            case (op)
                0, 1, 2: push_code(8'($urandom));
                3: rd(4'h8, "rnd_data", model_read(4'h8));
                4: rd(4'h4, "rnd_status", model_read(4'h4));
                5: begin
                    d[2] = ($urandom_range(0, 7) == 0);
                    mwrite(4'h0, d, s);
                end
                6: if ($urandom_range(0, 1) == 1) mwrite(4'h4, d, s);
                   else rd(4'h0, "rnd_ctrl", model_read(4'h0));
                default: if ($urandom_range(0, 1) == 1) mwrite(4'hC, d, s);
                         else rd(4'hC, "rnd_scratch", model_read(4'hC));
            endcase
            check("rnd_irq", 32'(irq), 32'(exp_irq()));
        end
        rd(4'h4, "final_status", exp_status());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
